// File: rtl/tl_pkg.sv
// Shared types and helpers for the TileLink request-channel scheduler slice.
package tl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  // Index width that stays at least 1 bit for degenerate sizes.
  function automatic int vbits(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/tl_wrr_pick.sv
// Rotate-priority picker: first eligible index at or after ptr, combinational, no backpressure.
// With nothing eligible, idx returns ptr and gnt is all zero.
module tl_wrr_pick
  import tl_pkg::*;
#(
  parameter int NumLinks = 4,
  localparam int LinkWidth = vbits(NumLinks)
) (
  input  logic [NumLinks-1:0]  elig,
  input  logic [LinkWidth-1:0] ptr,
  output logic [NumLinks-1:0]  gnt,
  output logic [LinkWidth-1:0] idx,
  output logic                 any
);

  logic [LinkWidth:0]   cand;
  logic [LinkWidth-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = ptr;
    any      = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < NumLinks; k++) begin
      cand = {1'b0, ptr} + (LinkWidth+1)'(k);
      if (cand >= (LinkWidth+1)'(NumLinks)) begin
        cand = cand - (LinkWidth+1)'(NumLinks);
      end
      cand_idx = cand[LinkWidth-1:0];
      if (!any && elig[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/tl_req_wrr_scheduler.sv
// Weighted round-robin A-channel scheduler: zero-latency mux, atomic bursts, hosts see out_ready_i.
// Optional per-host statistics counters behind TL_WRR_SCHED_STATS_EN.
module tl_req_wrr_scheduler
  import tl_pkg::*;
#(
  parameter int NumLinks       = 4,
  parameter int PayloadWidth   = 128,
  parameter int WeightWidth    = 4,
  parameter int MaxOutstanding = 8,
  localparam int LinkWidth = vbits(NumLinks),
  localparam int CntWidth  = vbits(MaxOutstanding + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumLinks-1:0]                    req_valid_i,
  output logic [NumLinks-1:0]                    req_ready_o,
  input  logic [NumLinks-1:0][PayloadWidth-1:0]  req_payload_i,
  input  logic [NumLinks-1:0]                    req_last_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [PayloadWidth-1:0]                out_payload_o,
  output logic                                   out_last_o,
  output logic [LinkWidth-1:0]                   out_idx_o,
  input  logic [NumLinks-1:0][WeightWidth-1:0]   cfg_weight_i,
  input  logic                                   rsp_done_i,
  input  logic [LinkWidth-1:0]                   rsp_done_idx_i,
`ifdef TL_WRR_SCHED_STATS_EN
  output logic [NumLinks-1:0][31:0]              stat_bursts_o,
  output logic [NumLinks-1:0][31:0]              stat_stall_o,
`endif
  output logic                                   busy_o
);

  sched_state_e state_q, state_d;
  logic [LinkWidth-1:0]               ptr_q, lk_q, lk_d, sel, pick_idx;
  logic [WeightWidth-1:0]             q_used_q;
  logic [NumLinks-1:0][CntWidth-1:0]  cnt_q;
  logic [NumLinks-1:0]                elig, pick_gnt, inc, dec;
  logic                               pick_any, accept, burst_end;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NumLinks; i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding)) &&
                (cfg_weight_i[i] != '0);
    end
  end

  tl_wrr_pick #(
    .NumLinks(NumLinks)
  ) u_pick (
    .elig(elig),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // A locked burst ignores eligibility: it was already counted when it started.
  always_comb begin
    sel         = pick_idx;
    out_valid_o = pick_any;
    req_ready_o = pick_gnt & {NumLinks{out_ready_i}};
    if (state_q == LOCKED) begin
      sel              = lk_q;
      out_valid_o      = req_valid_i[lk_q];
      req_ready_o      = '0;
      req_ready_o[lk_q] = out_ready_i && req_valid_i[lk_q];
    end
  end

  assign out_payload_o = req_payload_i[sel];
  assign out_last_o    = req_last_i[sel];
  assign out_idx_o     = sel;
  assign accept        = out_valid_o && out_ready_i;
  assign burst_end     = accept && out_last_o;
  assign busy_o        = (state_q == LOCKED) || (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !out_last_o) begin
          state_d = LOCKED;
          lk_d    = sel;
        end
      end
      LOCKED: begin
        if (accept && out_last_o) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NumLinks; i++) begin
      inc[i] = accept && (state_q == IDLE) && (sel == LinkWidth'(i));
      dec[i] = rsp_done_i && (rsp_done_idx_i == LinkWidth'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      lk_q     <= '0;
      ptr_q    <= '0;
      q_used_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
      // A host that finishes while ptr points elsewhere takes the turn; ptr's host forfeits it.
      if (burst_end) begin
        if ((sel == ptr_q) && (({1'b0, q_used_q} + 1'b1) < {1'b0, cfg_weight_i[sel]})) begin
          q_used_q <= q_used_q + 1'b1;
        end else begin
          ptr_q    <= (sel == LinkWidth'(NumLinks - 1)) ? '0 : sel + 1'b1;
          q_used_q <= '0;
        end
      end
      for (int i = 0; i < NumLinks; i++) begin
        if (inc[i] && !dec[i] && (cnt_q[i] != CntWidth'(MaxOutstanding))) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (dec[i] && !inc[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_done_i |-> ((cnt_q[rsp_done_idx_i] != '0) || inc[rsp_done_idx_i]));

`ifdef TL_WRR_SCHED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_bursts_o <= '0;
      stat_stall_o  <= '0;
    end else begin
      for (int i = 0; i < NumLinks; i++) begin
        if (burst_end && (sel == LinkWidth'(i))) begin
          stat_bursts_o[i] <= stat_bursts_o[i] + 32'd1;
        end
        if (req_valid_i[i] && !(out_valid_o && (sel == LinkWidth'(i)))) begin
          stat_stall_o[i] <= stat_stall_o[i] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tl_req_wrr_scheduler.sv
// Directed bench for tl_req_wrr_scheduler with a per-cycle reference model of the arbitration rules.
module tb_tl_req_wrr_scheduler;

  localparam int NL = 4;
  localparam int PW = 16;
  localparam int WW = 4;
  localparam int MO = 2;
  localparam int LW = 2;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic [NL-1:0]            req_valid_i, req_ready_o, req_last_i;
  logic [NL-1:0][PW-1:0]    req_payload_i;
  logic                     out_valid_o, out_ready_i, out_last_o;
  logic [PW-1:0]            out_payload_o;
  logic [LW-1:0]            out_idx_o;
  logic [NL-1:0][WW-1:0]    cfg_weight_i;
  logic                     rsp_done_i;
  logic [LW-1:0]            rsp_done_idx_i;
  logic                     busy_o;
`ifdef TL_WRR_SCHED_STATS_EN
  logic [NL-1:0][31:0]      stat_bursts_o, stat_stall_o;
`endif

  always #5 clk_i = ~clk_i;

  tl_req_wrr_scheduler #(
    .NumLinks(NL), .PayloadWidth(PW), .WeightWidth(WW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_payload_i(req_payload_i), .req_last_i(req_last_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_payload_o(out_payload_o), .out_last_o(out_last_o), .out_idx_o(out_idx_o),
    .cfg_weight_i(cfg_weight_i), .rsp_done_i(rsp_done_i), .rsp_done_idx_i(rsp_done_idx_i),
`ifdef TL_WRR_SCHED_STATS_EN
    .stat_bursts_o(stat_bursts_o), .stat_stall_o(stat_stall_o),
`endif
    .busy_o(busy_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Host agents: each host issues pend[i] bursts of blen[i] beats.
  int pend[NL], blen[NL], beat[NL];
  bit rsp_auto, rsp_pend;
  int rsp_host;
  int glog[$];
  logic [NL-1:0] seen_rdy;

  task automatic drive();
    for (int i = 0; i < NL; i++) begin
      req_valid_i[i]   = pend[i] > 0;
      req_last_i[i]    = (beat[i] == blen[i] - 1);
      req_payload_i[i] = PW'(i * 4096 + (pend[i] % 256) * 16 + beat[i] % 16);
    end
    rsp_done_i     = rsp_pend;
    rsp_done_idx_i = LW'(rsp_host);
  endtask

  task automatic step();
    int done_host;
    done_host = -1;
    @(negedge clk_i);
    for (int i = 0; i < NL; i++) begin
      seen_rdy[i] = seen_rdy[i] | req_ready_o[i];
      if (req_valid_i[i] && req_ready_o[i]) begin
        glog.push_back(i);
        if (beat[i] == blen[i] - 1) begin
          beat[i] = 0;
          pend[i]--;
          done_host = i;
        end else begin
          beat[i]++;
        end
      end
    end
    @(posedge clk_i);
    #1;
    rsp_pend = rsp_auto && (done_host >= 0);
    if (done_host >= 0) rsp_host = done_host;
    drive();
  endtask

  task automatic do_reset(input int cycles);
    rst_i    = 1'b1;
    rsp_auto = 1'b0;
    rsp_pend = 1'b0;
    for (int i = 0; i < NL; i++) begin
      pend[i] = 0; beat[i] = 0; blen[i] = 1;
    end
    drive();
    repeat (cycles) step();
    rst_i = 1'b0;
    drive();
    glog.delete();
    seen_rdy = '0;
  endtask

  // Reference model: pointer, quota used, lock and per-host in-flight bursts.
  int m_ptr, m_used, m_lk;
  int m_cnt[NL];
  bit m_locked;

  function automatic bit m_elig(input int i);
    return req_valid_i[i] && (m_cnt[i] < MO) && (cfg_weight_i[i] != 0);
  endfunction

  always @(negedge clk_i) begin : cmp
    int es, inc_h, dec_h, d, j;
    bit ev, any_cnt;
    logic [NL-1:0] erdy;
    if (rst_i) begin
      m_ptr = 0; m_used = 0; m_lk = 0; m_locked = 0;
      for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    end else begin
      ev = 0;
      es = m_ptr;
      if (m_locked) begin
        es = m_lk;
        ev = req_valid_i[m_lk];
      end else begin
        for (int k = 0; k < NL; k++) begin
          j = (m_ptr + k) % NL;
          if (!ev && m_elig(j)) begin
            ev = 1; es = j;
          end
        end
      end
      erdy = '0;
      if (ev && out_ready_i) erdy[es] = 1'b1;
      any_cnt = 0;
      for (int i = 0; i < NL; i++) any_cnt = any_cnt | (m_cnt[i] != 0);
      chk("out_valid", 64'(out_valid_o), 64'(ev));
      chk("out_idx", 64'(out_idx_o), 64'(es));
      chk("req_ready", 64'(req_ready_o), 64'(erdy));
      chk("busy", 64'(busy_o), 64'(m_locked || any_cnt));
      if (ev) begin
        chk("payload", 64'(out_payload_o), 64'(req_payload_i[es]));
        chk("last", 64'(out_last_o), 64'(req_last_i[es]));
      end
      inc_h = -1;
      dec_h = -1;
      if (ev && out_ready_i) begin
        if (!m_locked) inc_h = es;
        if (req_last_i[es]) begin
          if (es == m_ptr && m_used + 1 < int'(cfg_weight_i[es])) m_used++;
          else begin
            m_ptr = (es + 1) % NL; m_used = 0;
          end
          m_locked = 0;
        end else begin
          m_locked = 1; m_lk = es;
        end
      end
      if (rsp_done_i) dec_h = int'(rsp_done_idx_i);
      for (int i = 0; i < NL; i++) begin
        d = 0;
        if (i == inc_h) d++;
        if (i == dec_h) d--;
        if (d < 0 && m_cnt[i] == 0) d = 0;
        m_cnt[i] += d;
        if (m_cnt[i] > MO) m_cnt[i] = MO;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int exp1[10];
    int n1;
    exp1 = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3};
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    cfg_weight_i = '0;
    rsp_host = 0;
    do_reset(2);

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_idx", 64'(out_idx_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);

    // 1: weights {2,1,1,1}, all hosts streaming single beats, responses echoed
    for (int i = 0; i < NL; i++) cfg_weight_i[i] = (i == 0) ? WW'(2) : WW'(1);
    rsp_auto = 1'b1;
    for (int i = 0; i < NL; i++) pend[i] = 100;
    drive();
    repeat (10) step();
    chk("t1_count", 64'(glog.size()), 64'd10);
    for (int k = 0; k < 10; k++)
      chk("t1_seq", 64'((glog.size() > k) ? glog[k] : -1), 64'(exp1[k]));

    // 2: host1 4-beat burst, host0 joins at beat 2
    do_reset(2);
    for (int i = 0; i < NL; i++) cfg_weight_i[i] = WW'(1);
    rsp_auto = 1'b1;
    pend[1] = 1; blen[1] = 4;
    drive();
    step();
    pend[0] = 1; blen[0] = 1;
    drive();
    repeat (5) step();
    chk("t2_count", 64'(glog.size()), 64'd5);
    for (int k = 0; k < 4; k++)
      chk("t2_burst_idx", 64'((glog.size() > k) ? glog[k] : -1), 64'd1);
    chk("t2_after_burst", 64'((glog.size() > 4) ? glog[4] : -1), 64'd0);

    // 3: outstanding limit of 2 on host2
    do_reset(2);
    for (int i = 0; i < NL; i++) cfg_weight_i[i] = WW'(1);
    pend[2] = 5; blen[2] = 1;
    drive();
    repeat (5) step();
    #2;
    chk("t3_two_bursts", 64'(glog.size()), 64'd2);
    chk("t3_blocked_valid", 64'(out_valid_o), 64'd0);
    rsp_pend = 1'b1; rsp_host = 2;
    drive();
    step();
    chk("t3_rsp_cycle", 64'(glog.size()), 64'd2);
    step();
    chk("t3_resumed", 64'(glog.size()), 64'd3);

    // 4: response coinciding with a new burst start on host3
    do_reset(2);
    for (int i = 0; i < NL; i++) cfg_weight_i[i] = WW'(1);
    pend[3] = 1;
    drive();
    step();
    pend[3] = 1; rsp_pend = 1'b1; rsp_host = 3;
    drive();
    step();
    #2;
    chk("t4_accepts", 64'(glog.size()), 64'd2);
    chk("t4_busy_cnt1", 64'(busy_o), 64'd1);
    rsp_pend = 1'b1; rsp_host = 3;
    drive();
    step();
    #2;
    chk("t4_busy_cnt0", 64'(busy_o), 64'd0);

    // 5: zero weight masks host1
    do_reset(2);
    for (int i = 0; i < NL; i++) cfg_weight_i[i] = (i == 1) ? WW'(0) : WW'(1);
    rsp_auto = 1'b1;
    for (int i = 0; i < 3; i++) pend[i] = 4;
    drive();
    repeat (14) step();
    n1 = 0;
    foreach (glog[k]) if (glog[k] == 1) n1++;
    chk("t5_host1_grants", 64'(n1), 64'd0);
    chk("t5_host1_ready", 64'(seen_rdy[1]), 64'd0);
    chk("t5_others", 64'(glog.size()), 64'd8);

    // 6: reset in the middle of a locked burst
    do_reset(2);
    for (int i = 0; i < NL; i++) cfg_weight_i[i] = WW'(1);
    rsp_auto = 1'b1;
    pend[2] = 1;
    drive();
    step();
    pend[2] = 1; blen[2] = 4;
    drive();
    repeat (2) step();
    #2;
    chk("t6_busy_locked", 64'(busy_o), 64'd1);
    chk("t6_locked_idx", 64'(out_idx_o), 64'd2);
    do_reset(1);
    #2;
    chk("t6_rst_idx", 64'(out_idx_o), 64'd0);
    chk("t6_rst_busy", 64'(busy_o), 64'd0);
    chk("t6_rst_valid", 64'(out_valid_o), 64'd0);
    for (int i = 0; i < NL; i++) cfg_weight_i[i] = WW'(1);
    pend[1] = 1; pend[3] = 1;
    drive();
    #2;
    chk("t6_ptr_zero", 64'(out_idx_o), 64'd1);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
